// File: rtl/msg_pkg.sv
// Shared constants, FSM encoding and byte-count widths for the message serializer.
// No logic; imported by msg_serializer and its output stage.
package msg_pkg;
    localparam int BEAT_BYTES    = 8;
    localparam int HDR_BYTES     = 2;
    localparam int LEN_BYTES     = 2;
    localparam int MSG_MAX_BYTES = 32;
    localparam int SLOT_MAX      = HDR_BYTES + LEN_BYTES + MSG_MAX_BYTES;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PACK  = 2'd1,
        FLUSH = 2'd2
    } state_e;

    // Slot byte counts cover count header + length field + largest payload.
    typedef logic [$clog2(SLOT_MAX + 1)-1:0]   slot_cnt_t;
    typedef logic [$clog2(BEAT_BYTES + 1)-1:0] beat_cnt_t;
endpackage

// File: rtl/msg_serializer_axis_out.sv
// Registered AXI-Stream output stage: one-beat holding register, beat visible the cycle after load.
// Accepts a new beat when empty or when the held beat handshakes; fields hold while stalled.
module axis_out_reg
    import msg_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_vld,
    output logic                    in_rdy,
    input  logic [8*BEAT_BYTES-1:0] in_data,
    input  logic [BEAT_BYTES-1:0]   in_keep,
    input  logic                    in_last,
    input  logic                    in_user,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic [8*BEAT_BYTES-1:0] m_tdata,
    output logic [BEAT_BYTES-1:0]   m_tkeep,
    output logic                    m_tlast,
    output logic                    m_tuser
);
    assign in_rdy = !m_tvalid || m_tready;

    always_ff @(posedge clk) begin
        if (rst) begin
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tkeep  <= '0;
            m_tlast  <= 1'b0;
            m_tuser  <= 1'b0;
        end else if (in_rdy) begin
            m_tvalid <= in_vld;
            m_tdata  <= in_vld ? in_data : '0;
            m_tkeep  <= in_vld ? in_keep : '0;
            m_tlast  <= in_vld & in_last;
            m_tuser  <= in_vld & in_user;
        end
    end
endmodule

// File: rtl/msg_serializer.sv
// Packs whole messages into a 64-bit AXI-Stream packet: count, then per message length + payload, LE.
// First beat valid the cycle after accept; msg_ready depends only on registered state, never on m_tready.
module msg_serializer
    import msg_pkg::*;
#(
    parameter int MAX_MSG_BYTES = MSG_MAX_BYTES
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       msg_valid,
    output logic                       msg_ready,
    input  logic [15:0]                msg_count,
    input  logic [15:0]                msg_length,
    input  logic [8*MAX_MSG_BYTES-1:0] msg_data,
    input  logic                       msg_error,
    output logic                       m_tvalid,
    input  logic                       m_tready,
    output logic                       m_tlast,
    output logic [63:0]                m_tdata,
    output logic [7:0]                 m_tkeep,
    output logic                       m_tuser
);
    localparam int SLOT_BYTES = HDR_BYTES + LEN_BYTES + MAX_MSG_BYTES;

    state_e      state;
    logic [15:0] remaining;
    logic        pkt_err;
    logic        slot_vld, slot_last;
    slot_cnt_t   slot_len, slot_cur;
    logic [7:0]  slot_buf [SLOT_BYTES];
    logic [7:0]  res_buf  [BEAT_BYTES];
    beat_cnt_t   res_cnt;

    logic        accept, first, trunc, new_last, new_err;
    logic [15:0] len_field;
    slot_cnt_t   new_len;
    logic [7:0]  new_buf  [SLOT_BYTES];

    logic        active, step, issue, exhaust, beat_last, err_cur, src_last, out_rdy;
    slot_cnt_t   src_len, src_cur, avail, room, take, fill, idx;
    logic [7:0]  src_buf  [SLOT_BYTES];
    logic [7:0]  beat_byte [BEAT_BYTES];
    logic [63:0] beat_dat;
    logic [7:0]  beat_keep;

    assign msg_ready = !slot_vld && (state != FLUSH);
    assign accept    = msg_valid && msg_ready;

    // Incoming message rendered as its wire bytes: optional count header, length field, payload.
    always_comb begin
        first     = (state == IDLE);
        trunc     = msg_length > 16'(MAX_MSG_BYTES);
        len_field = trunc ? 16'(MAX_MSG_BYTES) : msg_length;
        for (int i = 0; i < SLOT_BYTES; i++) new_buf[i] = 8'h00;
        if (first) begin
            new_buf[0] = msg_count[7:0];
            new_buf[1] = msg_count[15:8];
            new_buf[2] = len_field[7:0];
            new_buf[3] = len_field[15:8];
            for (int i = 0; i < MAX_MSG_BYTES; i++) new_buf[4+i] = msg_data[8*i +: 8];
            new_len = slot_cnt_t'(len_field) + slot_cnt_t'(HDR_BYTES + LEN_BYTES);
        end else begin
            new_buf[0] = len_field[7:0];
            new_buf[1] = len_field[15:8];
            for (int i = 0; i < MAX_MSG_BYTES; i++) new_buf[2+i] = msg_data[8*i +: 8];
            new_len = slot_cnt_t'(len_field) + slot_cnt_t'(LEN_BYTES);
        end
        new_last = first ? (msg_count <= 16'd1) : (remaining == 16'd1);
        new_err  = (!first && pkt_err) | msg_error | trunc | (first && msg_count == 16'd0);
    end

    // A message accepted this cycle feeds the beat directly, saving a cycle of latency.
    always_comb begin
        for (int i = 0; i < SLOT_BYTES; i++) src_buf[i] = slot_vld ? slot_buf[i] : new_buf[i];
        src_len   = slot_vld ? slot_len : new_len;
        src_cur   = slot_vld ? slot_cur : '0;
        src_last  = slot_vld ? slot_last : new_last;
        err_cur   = slot_vld ? pkt_err : new_err;
        active    = slot_vld | accept;
        avail     = src_len - src_cur;
        room      = slot_cnt_t'(BEAT_BYTES) - slot_cnt_t'(res_cnt);
        take      = (avail < room) ? avail : room;
        fill      = slot_cnt_t'(res_cnt) + take;
        exhaust   = (take == avail);
        beat_last = src_last & exhaust;
        step      = active & out_rdy;
        issue     = step & ((fill == slot_cnt_t'(BEAT_BYTES)) | beat_last);
        beat_dat  = '0;
        beat_keep = '0;
        idx       = '0;
        for (int i = 0; i < BEAT_BYTES; i++) begin
            beat_byte[i] = 8'h00;
            idx = src_cur + slot_cnt_t'(i) - slot_cnt_t'(res_cnt);
            if (i < int'(res_cnt))
                beat_byte[i] = res_buf[i];
            else if (i < int'(fill) && int'(idx) < SLOT_BYTES)
                beat_byte[i] = src_buf[idx];
            beat_dat[8*i +: 8] = beat_byte[i];
            beat_keep[i]       = (i < int'(fill));
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < SLOT_BYTES; i++) slot_buf[i] <= new_buf[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= '0;
            pkt_err   <= 1'b0;
            slot_vld  <= 1'b0;
            slot_last <= 1'b0;
            slot_len  <= '0;
            slot_cur  <= '0;
            res_cnt   <= '0;
            for (int i = 0; i < BEAT_BYTES; i++) res_buf[i] <= 8'h00;
        end else begin
            if (accept) begin
                pkt_err   <= new_err;
                remaining <= first ? ((msg_count == 16'd0) ? 16'd0 : msg_count - 16'd1)
                                   : remaining - 16'd1;
                if (first) state <= PACK;
            end
            if (step) begin
                if (issue) begin
                    res_cnt <= '0;
                end else begin
                    res_cnt <= beat_cnt_t'(fill);
                    for (int i = 0; i < BEAT_BYTES; i++) res_buf[i] <= beat_byte[i];
                end
                slot_vld  <= !exhaust;
                slot_cur  <= src_cur + take;
                slot_len  <= src_len;
                slot_last <= src_last;
                if (beat_last) state <= FLUSH;
            end else if (accept) begin
                slot_vld  <= 1'b1;
                slot_cur  <= '0;
                slot_len  <= new_len;
                slot_last <= new_last;
            end
            if (state == FLUSH && m_tvalid && m_tready && m_tlast) state <= IDLE;
        end
    end

    axis_out_reg u_out (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (issue),
        .in_rdy   (out_rdy),
        .in_data  (beat_dat),
        .in_keep  (beat_keep),
        .in_last  (beat_last),
        .in_user  (beat_last & err_cur),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tdata  (m_tdata),
        .m_tkeep  (m_tkeep),
        .m_tlast  (m_tlast),
        .m_tuser  (m_tuser)
    );
endmodule

// File: tb/tb_msg_serializer.sv
// Scoreboard bench for msg_serializer: directed packets with hand-computed beats.
module tb_msg_serializer;
    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic        user;
    } beat_t;

    logic         clk, rst;
    logic         msg_valid, msg_ready, msg_error;
    logic [15:0]  msg_count, msg_length;
    logic [255:0] msg_data;
    logic         m_tvalid, m_tready, m_tlast, m_tuser;
    logic [63:0]  m_tdata;
    logic [7:0]   m_tkeep;

    int    checks = 0;
    int    failures = 0;
    int    hs_count = 0;
    bit    bp_en = 0;
    bit    ignore_beats = 0;
    beat_t exp_q[$];
    logic  prev_stall = 0;
    beat_t prev_beat;

    localparam logic [255:0] MSG_A = 256'ha5b0_0388_9560_8413_0858_045d_e506;
    localparam logic [255:0] MSG_B = 256'hd845a30c_85468052;

    msg_serializer dut (
        .clk        (clk),
        .rst        (rst),
        .msg_valid  (msg_valid),
        .msg_ready  (msg_ready),
        .msg_count  (msg_count),
        .msg_length (msg_length),
        .msg_data   (msg_data),
        .msg_error  (msg_error),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tlast    (m_tlast),
        .m_tdata    (m_tdata),
        .m_tkeep    (m_tkeep),
        .m_tuser    (m_tuser)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pops the expected beat on every handshake; checks hold stability while stalled.
    always @(negedge clk) begin
        beat_t got, want;
        got = {m_tdata, m_tkeep, m_tlast, m_tuser};
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!m_tvalid || got !== prev_beat) begin
                    failures++;
                    $display("FAIL stall_hold got vld=%0b %h/%h/%0b/%0b held %h/%h/%0b/%0b", m_tvalid,
                             got.data, got.keep, got.last, got.user,
                             prev_beat.data, prev_beat.keep, prev_beat.last, prev_beat.user);
                end
            end
            if (m_tvalid && m_tready) begin
                hs_count++;
                if (!ignore_beats) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_beat got %h/%h/%0b/%0b", got.data, got.keep, got.last, got.user);
                    end else begin
                        want = exp_q.pop_front();
                        if (got !== want) begin
                            failures++;
                            $display("FAIL beat got data=%h keep=%h last=%0b user=%0b expected data=%h keep=%h last=%0b user=%0b",
                                     got.data, got.keep, got.last, got.user,
                                     want.data, want.keep, want.last, want.user);
                        end
                    end
                end
            end
            prev_stall = m_tvalid && !m_tready;
            prev_beat  = got;
        end
    end

    task automatic push(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u);
        exp_q.push_back({d, k, l, u});
    endtask

    task automatic check1(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, want);
        end
    endtask

    task automatic check_reset(input string tag);
        check1({tag, "_tvalid"}, 64'(m_tvalid), 64'd0);
        check1({tag, "_tlast"}, 64'(m_tlast), 64'd0);
        check1({tag, "_tuser"}, 64'(m_tuser), 64'd0);
        check1({tag, "_tdata"}, m_tdata, 64'd0);
        check1({tag, "_tkeep"}, 64'(m_tkeep), 64'd0);
        check1({tag, "_msg_ready"}, 64'(msg_ready), 64'd1);
    endtask

    task automatic send_msg(input logic [15:0] cnt, input logic [15:0] len,
                            input logic [255:0] dat, input logic err);
        int n;
        @(posedge clk);
        #1;
        msg_valid  = 1'b1;
        msg_count  = cnt;
        msg_length = len;
        msg_data   = dat;
        msg_error  = err;
        n = 0;
        forever begin
            @(negedge clk);
            if (msg_ready) break;
            n++;
            if (n > 2000) begin
                checks++;
                failures++;
                $display("FAIL msg_ready_timeout got=0 expected=1");
                break;
            end
        end
        @(posedge clk);
        #1;
        msg_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_tvalid) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            checks++;
            failures++;
            $display("FAIL %s_drain_timeout pending=%0d expected=0", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic single_msg();
        push(64'habcddcef_00080001, 8'hff, 1'b0, 1'b0);
        push(64'h00000000_630d658d, 8'h0f, 1'b1, 1'b0);
        send_msg(16'd1, 16'd8, 256'h630d658d_abcddcef, 1'b0);
        wait_drain("single");
    endtask

    task automatic two_msg(input string tag);
        push(64'h045de506_000e0002, 8'hff, 1'b0, 1'b0);
        push(64'h03889560_84130858, 8'hff, 1'b0, 1'b0);
        push(64'h85468052_0008a5b0, 8'hff, 1'b0, 1'b0);
        push(64'h00000000_d845a30c, 8'h0f, 1'b1, 1'b0);
        send_msg(16'd2, 16'd14, MSG_A, 1'b0);
        send_msg(16'd2, 16'd8, MSG_B, 1'b0);
        wait_drain(tag);
    endtask

    initial begin
        logic [255:0] ramp;
        int base, n;
        rst = 1'b1;
        msg_valid = 1'b0;
        msg_count = '0;
        msg_length = '0;
        msg_data = '0;
        msg_error = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        single_msg();
        two_msg("two");

        // Exact fit: header + length + 4 bytes fill one beat.
        push(64'h44332211_00040001, 8'hff, 1'b1, 1'b0);
        send_msg(16'd1, 16'd4, 256'h44332211, 1'b0);
        wait_drain("exact");

        bp_en = 1'b1;
        two_msg("backpressure");
        bp_en = 1'b0;

        // msg_error on message 2 of 3: flagged only on the tlast beat.
        push(64'h0002a2a1_00020003, 8'hff, 1'b0, 1'b0);
        push(64'h0000c2c1_0002b2b1, 8'h3f, 1'b1, 1'b1);
        send_msg(16'd3, 16'd2, 256'ha2a1, 1'b0);
        send_msg(16'd3, 16'd2, 256'hb2b1, 1'b1);
        send_msg(16'd3, 16'd2, 256'hc2c1, 1'b0);
        wait_drain("err3");

        // Oversize length truncates to 32 bytes and flags the packet.
        for (int i = 0; i < 32; i++) ramp[8*i +: 8] = 8'(i);
        push(64'h03020100_00200001, 8'hff, 1'b0, 1'b0);
        push(64'h0b0a0908_07060504, 8'hff, 1'b0, 1'b0);
        push(64'h13121110_0f0e0d0c, 8'hff, 1'b0, 1'b0);
        push(64'h1b1a1918_17161514, 8'hff, 1'b0, 1'b0);
        push(64'h00000000_1f1e1d1c, 8'h0f, 1'b1, 1'b1);
        send_msg(16'd1, 16'd40, ramp, 1'b0);
        wait_drain("trunc");

        // Zero count closes after one message with error set.
        push(64'h00000000_00000000, 8'h0f, 1'b1, 1'b1);
        send_msg(16'd0, 16'd0, 256'h0, 1'b0);
        wait_drain("zero_count");

        // Zero-length message contributes only its length field.
        push(64'h00770001_00000002, 8'h7f, 1'b1, 1'b0);
        send_msg(16'd2, 16'd0, 256'h0, 1'b0);
        send_msg(16'd2, 16'd1, 256'h77, 1'b0);
        wait_drain("zero_len");

        // Reset after the second beat of an open packet.
        ignore_beats = 1'b1;
        base = hs_count;
        send_msg(16'd2, 16'd14, MSG_A, 1'b0);
        n = 0;
        while (hs_count < base + 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL mid_reset_beats got=%0d expected=2", hs_count - base);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset("mid_reset");
        @(posedge clk);
        #1 rst = 1'b0;
        ignore_beats = 1'b0;
        single_msg();

        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
